// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ImLength / InstrWidth : default fetch-address and instruction widths
//   if_state_e            : fetch FSM encoding (boot, run, flush)
//   image_word()          : instruction image held by the ROM (word a = 32'hA000_0000 | a)
//   sat_inc()             : saturating 32-bit increment for the optional perf counters
package instr_fetch_stage_pkg;

  localparam int unsigned ImLength   = 8;
  localparam int unsigned InstrWidth = 32;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } if_state_e;

  function automatic logic [31:0] image_word(input logic [31:0] addr);
    return 32'hA000_0000 | addr;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_bram.sv
// instr_mem_bram: single-port synchronous-read instruction ROM, one cycle of latency.
//   clk_i   : clock
//   re_i    : read enable; when low the output register keeps its previous word
//   addr_i  : word address
//   rdata_o : registered read data
// Words at or above Depth read as zero.
module instr_mem_bram import instr_fetch_stage_pkg::*; #(
  parameter int unsigned AddrWidth = ImLength,
  parameter int unsigned DataWidth = InstrWidth,
  parameter int unsigned Depth     = 2 ** AddrWidth
) (
  input  logic                 clk_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = (32'(addr_i) < Depth) ? DataWidth'(image_word(32'(addr_i))) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: fetch stage sitting beside PC_module.
//   CLK, RESET_N (synchronous, active low)
//   NPC_IN        : next sequential PC from PC_module
//   PC_OUT, PC_EN : fetch address and enable driven into PC_module
//   STALL         : decode cannot accept, freeze the pipeline
//   BRANCH_TAKEN, BRANCH_TARGET : redirect request (ignored while STALL=1)
//   INSTR, INSTR_PC, INSTR_VALID : registered instruction presented to decode
// Two-stage pipe: F1 = ROM read register (+ address, valid), F2 = output register.
// Optional macro IF_PERF_CNT_EN adds FETCH_CNT, STALL_CNT and FLUSH_CNT outputs.
module instr_fetch_stage import instr_fetch_stage_pkg::*; #(
  parameter int unsigned IM_LENGTH   = ImLength,
  parameter int unsigned INSTR_WIDTH = InstrWidth,
  parameter int unsigned IM_DEPTH    = 2 ** IM_LENGTH
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [IM_LENGTH-1:0]   NPC_IN,
  output logic [IM_LENGTH-1:0]   PC_OUT,
  output logic                   PC_EN,
  input  logic                   STALL,
  input  logic                   BRANCH_TAKEN,
  input  logic [IM_LENGTH-1:0]   BRANCH_TARGET,
  output logic [INSTR_WIDTH-1:0] INSTR,
  output logic [IM_LENGTH-1:0]   INSTR_PC,
  output logic                   INSTR_VALID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            FETCH_CNT,
  output logic [31:0]            STALL_CNT,
  output logic [31:0]            FLUSH_CNT
`endif
);

  if_state_e state_q, state_d;

  logic                   in_boot, advance, issue, squash;
  logic [IM_LENGTH-1:0]   fetch_addr;
  logic [INSTR_WIDTH-1:0] rom_rdata;

  logic [IM_LENGTH-1:0]   f1_pc_q, f1_pc_d;
  logic                   f1_valid_q, f1_valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [IM_LENGTH-1:0]   instr_pc_q, instr_pc_d;
  logic                   instr_valid_q, instr_valid_d;

  assign in_boot    = (state_q == StBoot);
  // Stall is only honoured once running; in boot the (empty) pipe keeps moving.
  assign advance    = in_boot | ~STALL;
  assign issue      = RESET_N & ~in_boot & ~STALL;
  // Redirect kills the word sitting in F1 as it moves into F2.
  assign squash     = issue & BRANCH_TAKEN;
  assign fetch_addr = BRANCH_TAKEN ? BRANCH_TARGET : NPC_IN;

  assign PC_OUT = RESET_N ? fetch_addr : '0;
  assign PC_EN  = issue;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:         state_d = StRun;
      StRun, StFlush: state_d = squash ? StFlush : StRun;
      default:        state_d = StBoot;
    endcase
  end

  always_comb begin
    f1_pc_d       = f1_pc_q;
    f1_valid_d    = f1_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    if (advance) begin
      f1_pc_d       = fetch_addr;
      f1_valid_d    = issue;
      instr_d       = rom_rdata;
      instr_pc_d    = f1_pc_q;
      instr_valid_d = f1_valid_q & ~squash;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q       <= StBoot;
      f1_pc_q       <= '0;
      f1_valid_q    <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      f1_pc_q       <= f1_pc_d;
      f1_valid_q    <= f1_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  instr_mem_bram #(
    .AddrWidth (IM_LENGTH),
    .DataWidth (INSTR_WIDTH),
    .Depth     (IM_DEPTH)
  ) u_imem (
    .clk_i   (CLK),
    .re_i    (advance),
    .addr_i  (fetch_addr),
    .rdata_o (rom_rdata)
  );

  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign INSTR_VALID = instr_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = sat_inc(fetch_cnt_q, issue);
    stall_cnt_d = sat_inc(stall_cnt_q, STALL & ~in_boot);
    flush_cnt_d = sat_inc(flush_cnt_q, squash);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule
